// File: rtl/switch_lamp_ctrl.sv
// Multi-channel switch-to-lamp controller: synchroniser, debounce, level/toggle
// lamp logic with auto-off timeout, shared PWM dimmer and on/off event pulses.
module switch_lamp_ctrl #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned TIMEOUT_CYC  = 16,
    parameter int unsigned PWM_W        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       sw_in,
    input  logic [N_CH-1:0]       mode,
    input  logic [N_CH*PWM_W-1:0] bright,
    input  logic                  timeout_en,
    output logic [N_CH-1:0]       lamp_on,
    output logic [N_CH-1:0]       lamp_drive,
    output logic [N_CH-1:0]       on_event,
    output logic [N_CH-1:0]       off_event
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [N_CH-1:0]  sync1;
    logic [N_CH-1:0]  sync2;
    logic [N_CH-1:0]  sw_stable;
    logic [N_CH-1:0]  sw_stable_d;
    logic [CNT_W-1:0] db_cnt [N_CH];
    logic [N_CH-1:0]  mode_r;
    logic [N_CH-1:0]  lockout;
    logic [TMR_W-1:0] timer [N_CH];
    logic [N_CH-1:0]  lamp_d;
    logic [PWM_W-1:0] pwm_cnt;

    logic [N_CH-1:0]  press_c;
    logic [N_CH-1:0]  mode_chg_c;
    logic [N_CH-1:0]  expire_c;

    // Per-channel press, mode-change and timeout-expiry qualifiers
    always_comb begin
        press_c    = sw_stable & ~sw_stable_d;
        mode_chg_c = mode ^ mode_r;
        expire_c   = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            expire_c[i] = lamp_on[i] & timeout_en & (timer[i] == TMR_LAST);
        end
    end

    // Two-flop synchroniser followed by a consecutive-agreement debouncer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            sw_stable   <= '0;
            sw_stable_d <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1       <= sw_in;
            sync2       <= sync1;
            sw_stable_d <= sw_stable;
            for (int i = 0; i < int'(N_CH); i++) begin
                if (sync2[i] == sw_stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    sw_stable[i] <= sync2[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Lamp state: mode change beats timeout, timeout beats switch activity
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_r  <= '0;
            lockout <= '0;
            lamp_on <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                timer[i] <= '0;
            end
        end else begin
            mode_r <= mode;
            for (int i = 0; i < int'(N_CH); i++) begin
                if (mode_chg_c[i]) begin
                    lamp_on[i] <= 1'b0;
                    timer[i]   <= '0;
                    lockout[i] <= 1'b0;
                end else if (expire_c[i]) begin
                    lamp_on[i] <= 1'b0;
                    timer[i]   <= '0;
                    // only level mode needs a release before re-lighting
                    lockout[i] <= ~mode_r[i];
                end else begin
                    if (mode_r[i]) begin
                        lamp_on[i] <= lamp_on[i] ^ press_c[i];
                    end else begin
                        lamp_on[i] <= sw_stable[i] & ~lockout[i];
                    end
                    if (!sw_stable[i]) begin
                        lockout[i] <= 1'b0;
                    end
                    if (lamp_on[i] && timeout_en) begin
                        timer[i] <= timer[i] + TMR_W'(1);
                    end else begin
                        timer[i] <= '0;
                    end
                end
            end
        end
    end

    // Shared PWM counter, dimmed drive and lamp transition events
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt    <= '0;
            lamp_d     <= '0;
            lamp_drive <= '0;
            on_event   <= '0;
            off_event  <= '0;
        end else begin
            pwm_cnt   <= pwm_cnt + PWM_W'(1);
            lamp_d    <= lamp_on;
            on_event  <= lamp_on & ~lamp_d;
            off_event <= ~lamp_on & lamp_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                lamp_drive[i] <= lamp_on[i] &
                                 ((bright[i*int'(PWM_W) +: PWM_W] == {PWM_W{1'b1}}) |
                                  (pwm_cnt < bright[i*int'(PWM_W) +: PWM_W]));
            end
        end
    end

endmodule

// File: tb/tb_switch_lamp_ctrl.sv
// Bench for switch_lamp_ctrl: vector table, directed corner sequences and a
// randomized run against a behavioural model.
module tb_switch_lamp_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned D = 4;
    localparam int unsigned T = 16;
    localparam int unsigned W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   sw_in;
    logic [N-1:0]   mode;
    logic [N*W-1:0] bright;
    logic           timeout_en;
    logic [N-1:0]   lamp_on;
    logic [N-1:0]   lamp_drive;
    logic [N-1:0]   on_event;
    logic [N-1:0]   off_event;

    int checks = 0;
    int errors = 0;

    switch_lamp_ctrl #(
        .N_CH(N), .DEBOUNCE_CYC(D), .TIMEOUT_CYC(T), .PWM_W(W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .mode(mode), .bright(bright),
        .timeout_en(timeout_en), .lamp_on(lamp_on), .lamp_drive(lamp_drive),
        .on_event(on_event), .off_event(off_event)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0] sw;
        int           n;
        logic [N-1:0] lamp;
        logic [N-1:0] on_e;
        logic [N-1:0] off_e;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [N-1:0] sw, input int n, input logic [N-1:0] lamp,
                                input logic [N-1:0] on_e, input logic [N-1:0] off_e);
        vec_t v;
        v.sw = sw; v.n = n; v.lamp = lamp; v.on_e = on_e; v.off_e = off_e;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    logic [N-1:0] sync_q[$];
    bit  m_stable[N], m_stable_old[N], m_lamp[N], m_lamp_old[N], m_locked[N], m_mode[N];
    int  m_streak[N], m_armed[N];
    int  m_phase;
    logic [N-1:0] exp_lamp, exp_drive, exp_on, exp_off;

    task automatic model_edge(input logic r, input logic [N-1:0] sw, input logic [N-1:0] md,
                              input logic ten, input logic [N*W-1:0] br);
        logic [N-1:0] seen;
        int  b;
        bit  pressed, lit;
        if (!r) begin
            sync_q.delete();
            sync_q.push_back('0);
            sync_q.push_back('0);
            for (int c = 0; c < int'(N); c++) begin
                m_stable[c] = 0; m_stable_old[c] = 0; m_lamp[c] = 0; m_lamp_old[c] = 0;
                m_locked[c] = 0; m_mode[c] = 0; m_streak[c] = 0; m_armed[c] = 0;
            end
            m_phase = 0;
            exp_lamp = '0; exp_drive = '0; exp_on = '0; exp_off = '0;
            return;
        end
        seen = sync_q.pop_front();
        sync_q.push_back(sw);
        for (int c = 0; c < int'(N); c++) begin
            b = int'(br[c*int'(W) +: W]);
            exp_drive[c] = m_lamp[c] && (b == (1 << W) - 1 || m_phase < b);
            exp_on[c]    = m_lamp[c] && !m_lamp_old[c];
            exp_off[c]   = !m_lamp[c] && m_lamp_old[c];
            pressed = m_stable[c] && !m_stable_old[c];
            if (md[c] != m_mode[c]) begin
                lit = 0; m_locked[c] = 0; m_armed[c] = 0;
            end else if (ten && m_lamp[c] && m_armed[c] + 1 == int'(T)) begin
                lit = 0; m_armed[c] = 0;
                if (!md[c]) m_locked[c] = 1;
            end else begin
                lit = md[c] ? (m_lamp[c] ^ pressed) : (m_stable[c] && !m_locked[c]);
                if (!m_stable[c]) m_locked[c] = 0;
                m_armed[c] = (m_lamp[c] && ten) ? m_armed[c] + 1 : 0;
            end
            m_lamp_old[c] = m_lamp[c];
            m_lamp[c]     = lit;
            exp_lamp[c]   = lit;
            m_mode[c]     = md[c];
            m_stable_old[c] = m_stable[c];
            if (seen[c] != m_stable[c]) begin
                m_streak[c]++;
                if (m_streak[c] == int'(D)) begin
                    m_stable[c] = !m_stable[c];
                    m_streak[c] = 0;
                end
            end else begin
                m_streak[c] = 0;
            end
        end
        m_phase = (m_phase + 1) % (1 << W);
    endtask

    // Toggle-mode press on channel 2, then release with no lamp effect
    task automatic toggle_press(input logic exp_l);
        sw_in[2] = 1'b1;
        step(7);
        chk("tog_lamp", 32'(lamp_on[2]), 32'(exp_l));
        step(1);
        chk("tog_on_event", 32'(on_event[2]), 32'(exp_l));
        chk("tog_off_event", 32'(off_event[2]), 32'(!exp_l));
        step(4);
        sw_in[2] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("tog_release_lamp", 32'(lamp_on[2]), 32'(exp_l));
            chk("tog_release_events", 32'({on_event[2], off_event[2]}), 32'(0));
        end
    endtask

    int cnt;
    int ch;

    initial begin
        rst_n = 1'b0; sw_in = '0; mode = '0; bright = '1; timeout_en = 1'b0;
        step(2);
        chk("reset_outputs", 32'({lamp_on, lamp_drive, on_event, off_event}), 32'(0));
        rst_n = 1'b1;

        // level latency, glitch rejection, minimum accepted pulse, release
        tbl.push_back(mk(4'b0001, 6, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 1, 4'b0001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 1, 4'b0001, 4'b0001, 4'b0000));
        tbl.push_back(mk(4'b0001, 1, 4'b0001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0011, 3, 4'b0001, 4'b0000, 4'b0000));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(4'b0001, 2, 4'b0001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0011, 4, 4'b0001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 2, 4'b0001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 1, 4'b0011, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 1, 4'b0011, 4'b0010, 4'b0000));
        tbl.push_back(mk(4'b0001, 2, 4'b0011, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 1, 4'b0001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 1, 4'b0001, 4'b0000, 4'b0010));
        tbl.push_back(mk(4'b0001, 1, 4'b0001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 6, 4'b0001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0000, 1, 4'b0000, 4'b0000, 4'b0001));
        tbl.push_back(mk(4'b0000, 4, 4'b0000, 4'b0000, 4'b0000));

        foreach (tbl[i]) begin
            sw_in = tbl[i].sw;
            step(tbl[i].n);
            chk($sformatf("tbl%0d_lamp_on", i), 32'(lamp_on), 32'(tbl[i].lamp));
            chk($sformatf("tbl%0d_on_event", i), 32'(on_event), 32'(tbl[i].on_e));
            chk($sformatf("tbl%0d_off_event", i), 32'(off_event), 32'(tbl[i].off_e));
        end

        // toggle mode on channel 2
        mode = 4'b0100;
        step(2);
        chk("tog_start_lamp", 32'(lamp_on), 32'(0));
        toggle_press(1'b1);
        toggle_press(1'b0);
        toggle_press(1'b1);

        // mode change while lit forces the lamp off with an off event
        mode = 4'b0000;
        step(1);
        chk("modechg_lamp", 32'(lamp_on), 32'(0));
        step(1);
        chk("modechg_off_event", 32'(off_event), 32'(4'b0100));
        chk("modechg_lamp_stays", 32'(lamp_on), 32'(0));

        // auto-off timeout on channel 3 in level mode
        timeout_en = 1'b1;
        sw_in = 4'b1000;
        step(7);
        chk("tmo_rise", 32'(lamp_on[3]), 32'(1));
        for (int i = 1; i < int'(T); i++) begin
            step(1);
            chk($sformatf("tmo_high_%0d", i), 32'(lamp_on[3]), 32'(1));
        end
        step(1);
        chk("tmo_expire", 32'(lamp_on[3]), 32'(0));
        step(1);
        chk("tmo_off_event", 32'(off_event[3]), 32'(1));
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("tmo_lockout", 32'(lamp_on[3]), 32'(0));
        end
        sw_in = 4'b0000;
        step(12);
        chk("tmo_released", 32'(lamp_on[3]), 32'(0));
        sw_in = 4'b1000;
        step(7);
        chk("tmo_repress", 32'(lamp_on[3]), 32'(1));
        timeout_en = 1'b0;
        sw_in = 4'b0000;
        step(12);
        chk("tmo_cleanup", 32'(lamp_on), 32'(0));

        // PWM dimming on channel 0
        bright = 16'hFFF4;
        sw_in = 4'b0001;
        step(9);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            step(1);
            cnt += int'(lamp_drive[0]);
        end
        chk("pwm_bright4", 32'(cnt), 32'(8));
        chk("pwm_idle_channels", 32'(lamp_drive[3:1]), 32'(0));
        bright = 16'hFFFF;
        step(2);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            cnt += int'(lamp_drive[0]);
        end
        chk("pwm_bright15", 32'(cnt), 32'(16));
        bright = 16'hFFF0;
        step(2);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            cnt += int'(lamp_drive[0]);
        end
        chk("pwm_bright0", 32'(cnt), 32'(0));

        // reset while lamps are lit and timers are counting
        bright = 16'hFFFF;
        sw_in = 4'b1001;
        step(8);
        chk("rst_pre_lamp", 32'(lamp_on), 32'(4'b1001));
        timeout_en = 1'b1;
        step(5);
        chk("rst_mid_lamp", 32'(lamp_on), 32'(4'b1001));
        rst_n = 1'b0;
        sw_in = 4'b0000;
        step(1);
        chk("rst_mid_outputs", 32'({lamp_on, lamp_drive, on_event, off_event}), 32'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("rst_after_quiet", 32'({lamp_on, lamp_drive, on_event, off_event}), 32'(0));
        end
        timeout_en = 1'b0;
        sw_in = 4'b0001;
        step(7);
        chk("rst_fresh_press", 32'(lamp_on), 32'(4'b0001));
        step(1);
        chk("rst_fresh_on_event", 32'(on_event), 32'(4'b0001));
        sw_in = 4'b0000;
        step(12);

        // randomized run against the model
        rst_n = 1'b0;
        model_edge(rst_n, sw_in, mode, timeout_en, bright);
        step(1);
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            for (int c = 0; c < int'(N); c++) begin
                if ($urandom_range(0, (c < 2) ? 5 : 29) == 0) sw_in[c] = ~sw_in[c];
            end
            if ($urandom_range(0, 99) == 0) begin
                ch = int'($urandom_range(0, N - 1));
                mode[ch] = ~mode[ch];
            end
            if ($urandom_range(0, 63) == 0) timeout_en = ~timeout_en;
            if ($urandom_range(0, 31) == 0) bright = 16'($urandom);
            model_edge(rst_n, sw_in, mode, timeout_en, bright);
            step(1);
            chk("rnd_lamp_on", 32'(lamp_on), 32'(exp_lamp));
            chk("rnd_lamp_drive", 32'(lamp_drive), 32'(exp_drive));
            chk("rnd_on_event", 32'(on_event), 32'(exp_on));
            chk("rnd_off_event", 32'(off_event), 32'(exp_off));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
